// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshakes on both sides and a
// saturating back-pressure counter.
// Optional feature: define PIPE_SKID_EN to add a second (skid) entry.
// With the skid entry, in_ready comes straight from a flop. Without it, a
// single entry is held and in_ready = !out_valid || out_ready.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              rdy_q;
  logic              vld;
  logic              enq;
  logic              deq;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  // Undefined encodings present nothing, i.e. behave as EMPTY.
  assign vld      = (state_q == ONE) || (state_q == TWO);
  assign in_ready = rdy_q;
`else
  assign vld      = (state_q == ONE);
  // rdy_q keeps in_ready low during reset and until the first edge after it.
  assign in_ready = rdy_q && (!vld || out_ready);
`endif

  assign enq       = in_valid && in_ready;
  assign deq       = vld && out_ready;
  assign out_valid = vld;
  assign out_data  = data_q;
  assign out_ctrl  = vld ? ctrl_q : '0;
  assign stall_cnt = stall_q;

  // Occupancy transitions, payload steering and stall counting.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
`ifdef PIPE_SKID_EN
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
`endif
    case (state_q)
      ONE: begin
        if (enq && deq) begin
          data_d = in_data;
          ctrl_d = in_ctrl;
        end else if (enq) begin
`ifdef PIPE_SKID_EN
          // Output is blocked: park the new entry in the skid slot.
          state_d     = TWO;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
`endif
        end else if (deq) begin
          state_d = EMPTY;
          ctrl_d  = '0;
        end
      end
`ifdef PIPE_SKID_EN
      TWO: begin
        // in_ready is low here, so only a dequeue can happen.
        if (deq) begin
          state_d = ONE;
          data_d  = skid_data_q;
          ctrl_d  = skid_ctrl_q;
        end
      end
`endif
      default: begin
        if (enq) begin
          state_d = ONE;
          data_d  = in_data;
          ctrl_d  = in_ctrl;
        end else begin
          state_d = EMPTY;
          ctrl_d  = '0;
        end
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      ctrl_d  = '0;
    end
    stall_d = stall_q;
    if (vld && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ctrl_q  <= '0;
      stall_q <= '0;
      rdy_q   <= 1'b0;
`ifdef PIPE_SKID_EN
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      stall_q <= stall_d;
`ifdef PIPE_SKID_EN
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      rdy_q       <= (state_d != TWO);
`else
      rdy_q       <= 1'b1;
`endif
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64: payload width, not cleared on flush.
REQ-002 SHALL have parameter CTRL_W, default 8: control width, zeroed on flush and whenever the output is empty.
REQ-003 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1: synchronous kill of all held entries.
REQ-007 SHALL have port in_valid  input  1: upstream offers an entry.
REQ-008 SHALL have port in_ready  output  1: stage accepts an entry this cycle.
REQ-009 SHALL have port in_data  input  DATA_W: upstream payload.
REQ-010 SHALL have port in_ctrl  input  CTRL_W: upstream control bits.
REQ-011 SHALL have port out_valid  output  1: stage presents an entry.
REQ-012 SHALL have port out_ready  input  1: downstream accepts the presented entry.
REQ-013 SHALL have port out_data  output  DATA_W: presented payload.
REQ-014 SHALL have port out_ctrl  output  CTRL_W: presented control, 0 when out_valid=0.
REQ-015 SHALL have port stall_cnt  output  CNT_W: saturating count of back-pressured cycles.

Function
REQ-016 SHALL complete a transfer on each side only in a cycle where valid and ready are both 1 at the rising edge.
REQ-017 SHALL pass entries in strict FIFO order, never dropping or duplicating one except on flush.
REQ-018 SHALL present an accepted entry on out_* in the cycle after acceptance, a latency of exactly 1 cycle.
REQ-019 SHALL sustain one transfer per cycle while out_ready=1 continuously.
REQ-020 SHALL hold out_valid, out_data and out_ctrl stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drive out_ctrl = 0 whenever out_valid = 0, so that a bubble carries no control side effects.
REQ-022 SHALL, when flush=1, next cycle reach the state with no valid entries and out_ctrl=0, discarding any same-cycle input handshake; flush overrides in_valid and out_ready.
REQ-023 SHALL increment stall_cnt by 1 in each cycle with out_valid=1 and out_ready=0, and flush SHALL NOT clear stall_cnt.
REQ-024 SHALL saturate stall_cnt at 2^CNT_W-1 without wrap-around.
REQ-025 SHALL use occupancy states EMPTY, ONE and TWO (TWO exists only with the skid buffer), and SHALL treat any other encoding as EMPTY.

Reset
REQ-026 SHALL, on rst_n=0 regardless of clk, immediately force: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
REQ-027 SHALL force in_ready=0 during reset and drive in_ready=1 from the first rising edge after rst_n deasserts.
REQ-028 SHALL, on reset asserted mid-transfer, discard all held entries and count nothing in that cycle.

Configuration
REQ-029 SHALL, with PIPE_SKID_EN defined, add a second (skid) entry: EMPTY->ONE on accept; ONE->TWO on accept without dequeue; TWO->ONE on dequeue.
REQ-030 SHALL, with PIPE_SKID_EN defined, drive in_ready from a flop as 1 exactly when state != TWO, with no combinational path from out_ready to in_ready.
REQ-031 SHALL, with PIPE_SKID_EN defined, on dequeue in TWO move the skid entry to the output in the same edge, keeping the one-cycle latency for the older entry.
REQ-032 SHALL, without PIPE_SKID_EN, hold a single entry with in_ready = !out_valid || out_ready combinationally, and never enter state TWO.

Verification
REQ-033 SHALL cover: reset deasserted, in_valid=1 for 4 cycles with data 0x1..0x4, out_ready=1 -> out_data 0x1..0x4 on consecutive cycles each 1 cycle after accept, stall_cnt=0.
REQ-034 SHALL cover, with PIPE_SKID_EN: out_ready=0 while 3 entries are offered -> exactly 2 accepted, in_ready=0 from the 3rd cycle, stall_cnt increments each cycle; out_ready=1 -> FIFO order preserved.
REQ-035 SHALL cover: flush=1 with in_valid=1, ctrl=0xFF and the stage holding data -> next cycle out_valid=0, out_ctrl=0x00, the incoming entry is lost, stall_cnt unchanged.
REQ-036 SHALL cover: CNT_W=4, out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
REQ-037 SHALL cover: rst_n=0 asserted between clock edges while state TWO -> outputs reach reset values without waiting for a clk edge, and in_ready=1 one edge after release.
REQ-038 SHALL cover, without PIPE_SKID_EN: the stage full, out_ready toggled 1/0 per cycle with in_valid=1 -> in_ready follows out_ready in the same cycle, no loss or duplication.
